// File: rtl/bv_priority_encoder_if.sv
// Match-vector input and result-FIFO output bundle for bv_priority_encoder.
// master drives vectors and consumes results; slave is the encoder.
interface bv_priority_encoder_if #(
    parameter int rule_num = 128,
    parameter int idx_w    = 7
);
    logic                bv_in_valid;
    logic [rule_num-1:0] bv_in;
    logic                result_valid;
    logic                result_hit;
    logic [idx_w-1:0]    result_id;
    logic                result_ready;
    logic                fifo_full;
    logic [15:0]         drop_count;

    modport master (
        output bv_in_valid, bv_in, result_ready,
        input  result_valid, result_hit, result_id, fifo_full, drop_count
    );

    modport slave (
        input  bv_in_valid, bv_in, result_ready,
        output result_valid, result_hit, result_id, fifo_full, drop_count
    );
endinterface

// File: rtl/bv_priority_encoder.sv
// Lowest-set-bit priority encoder over a rule match vector, results queued in an 8-deep FWFT FIFO.
// Latency: 2 cycles from sampled vector to result_valid (FIFO empty), one vector per cycle.
// Backpressure: none upstream; a result arriving at a full FIFO with no pop is dropped and counted.
module bv_priority_encoder #(
    parameter int rule_num = 128,
    parameter int idx_w    = 7
) (
    input  logic                 clk,
    input  logic                 reset,
    bv_priority_encoder_if.slave bus
);
    localparam int seg_w   = idx_w - 4;
    localparam int seg_num = rule_num / 16;
    localparam int depth   = 8;

    typedef struct packed {
        logic             hit;
        logic [idx_w-1:0] id;
    } res_t;

    logic [seg_num-1:0] c1_flag;
    logic [3:0]         c1_off [seg_num];
    logic               s1_vld;
    logic [seg_num-1:0] s1_flag;
    logic [3:0]         s1_off [seg_num];
    res_t               s2_res;

    res_t               mem [depth];
    logic [2:0]         wr_ptr;
    logic [2:0]         rd_ptr;
    logic [3:0]         count;
    logic [15:0]        drop_cnt;
    logic               empty;
    logic               full;
    logic               pop;
    logic               push;
    logic               drop;

    // Stage 1: per 16-bit segment, any-bit flag and lowest set offset.
    always_comb begin
        c1_flag = '0;
        for (int s = 0; s < seg_num; s++) begin
            c1_flag[s] = |bus.bv_in[s*16 +: 16];
            c1_off[s]  = 4'd0;
            for (int b = 15; b >= 0; b--) begin
                if (bus.bv_in[s*16 + b]) begin
                    c1_off[s] = 4'(b);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            s1_vld  <= 1'b0;
            s1_flag <= '0;
            s1_off  <= '{default: '0};
        end else begin
            s1_vld  <= bus.bv_in_valid;
            s1_flag <= c1_flag;
            s1_off  <= c1_off;
        end
    end

    // Stage 2: lowest flagged segment wins; result goes straight into the FIFO write port.
    always_comb begin
        s2_res = '0;
        for (int s = seg_num - 1; s >= 0; s--) begin
            if (s1_flag[s]) begin
                s2_res.id = {seg_w'(s), s1_off[s]};
            end
        end
        s2_res.hit = |s1_flag;
    end

    assign empty = (count == 4'd0);
    assign full  = (count == 4'd8);
    assign pop   = !empty && bus.result_ready;
    assign push  = s1_vld && (!full || pop);
    assign drop  = s1_vld && full && !pop;

    always_ff @(posedge clk) begin
        if (reset && push) begin
            mem[wr_ptr] <= s2_res;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr   <= 3'd0;
            rd_ptr   <= 3'd0;
            count    <= 4'd0;
            drop_cnt <= 16'd0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 3'd1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 3'd1;
            end
            if (push && !pop) begin
                count <= count + 4'd1;
            end else if (!push && pop) begin
                count <= count - 4'd1;
            end
            if (drop && (drop_cnt != 16'hFFFF)) begin
                drop_cnt <= drop_cnt + 16'd1;
            end
        end
    end

    // Head fields are masked while empty so stale memory never shows on the outputs.
    assign bus.result_valid = !empty;
    assign bus.result_hit   = !empty && mem[rd_ptr].hit;
    assign bus.result_id    = empty ? '0 : mem[rd_ptr].id;
    assign bus.fifo_full    = full;
    assign bus.drop_count   = drop_cnt;
endmodule

// File: tb/tb_bv_priority_encoder.sv
// Bench for bv_priority_encoder: directed scenarios plus randomized traffic against a queue-based model.
module tb_bv_priority_encoder;
    localparam int rule_num = 128;
    localparam int idx_w    = 7;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    bv_priority_encoder_if #(.rule_num(rule_num), .idx_w(idx_w)) bus ();

    bv_priority_encoder #(.rule_num(rule_num), .idx_w(idx_w)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        bit hit;
        int id;
    } res_t;

    typedef struct {
        int id;
        bit hit;
        int cyc;
    } pop_t;

    int   errors = 0;
    int   checks = 0;
    int   cyc    = 0;
    bit   cmp_en = 1'b0;
    res_t mq[$];
    bit   p_vld;
    res_t p_res;
    int   m_drops;
    pop_t plog[$];

    function automatic res_t ref_encode(logic [rule_num-1:0] v);
        res_t r;
        r.hit = 1'b0;
        r.id  = 0;
        for (int k = 0; k < rule_num; k++) begin
            if (v[k]) begin
                r.hit = 1'b1;
                r.id  = k;
                break;
            end
        end
        return r;
    endfunction

    function automatic logic [rule_num-1:0] onehot(int k);
        logic [rule_num-1:0] v;
        v    = '0;
        v[k] = 1'b1;
        return v;
    endfunction

    function automatic logic [rule_num-1:0] rand_vec();
        logic [rule_num-1:0] v;
        int mode;
        v    = '0;
        mode = $urandom_range(0, 3);
        case (mode)
            1: v[$urandom_range(0, rule_num - 1)] = 1'b1;
            2: for (int w = 0; w < rule_num / 32; w++) v[w*32 +: 32] = $urandom;
            3: begin
                v[$urandom_range(0, rule_num - 1)] = 1'b1;
                v[$urandom_range(0, rule_num - 1)] = 1'b1;
            end
            default: v = '0;
        endcase
        return v;
    endfunction

    task automatic check(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference: results wait one cycle after sampling, then enter a bounded queue.
    always @(posedge clk) begin : model
        bit m_full;
        bit m_pop;
        cyc <= cyc + 1;
        if (!reset) begin
            p_vld   <= 1'b0;
            mq.delete();
            m_drops <= 0;
        end else begin
            m_full = (mq.size() == 8);
            m_pop  = (mq.size() != 0) && bus.result_ready;
            if (m_pop) void'(mq.pop_front());
            if (p_vld) begin
                if (!m_full || m_pop) mq.push_back(p_res);
                else if (m_drops < 65535) m_drops <= m_drops + 1;
            end
            p_vld <= bus.bv_in_valid;
            p_res <= ref_encode(bus.bv_in);
        end
        cmp_en <= 1'b1;
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            check("valid", int'(bus.result_valid), int'(mq.size() != 0));
            if (mq.size() != 0) begin
                check("hit", int'(bus.result_hit), int'(mq[0].hit));
                check("id", int'(bus.result_id), mq[0].id);
            end
            check("full", int'(bus.fifo_full), int'(mq.size() == 8));
            check("drops", int'(bus.drop_count), m_drops);
            if (bus.result_valid && bus.result_ready && reset) begin
                pop_t p;
                p.id  = int'(bus.result_id);
                p.hit = bus.result_hit;
                p.cyc = cyc;
                plog.push_back(p);
            end
        end
    end

    initial begin
        reset            = 1'b0;
        bus.bv_in_valid  = 1'b0;
        bus.bv_in        = '0;
        bus.result_ready = 1'b0;
        step();
        step();
        check("rst_valid", int'(bus.result_valid), 0);
        check("rst_hit", int'(bus.result_hit), 0);
        check("rst_id", int'(bus.result_id), 0);
        check("rst_full", int'(bus.fifo_full), 0);
        check("rst_drops", int'(bus.drop_count), 0);
        reset = 1'b1;

        // Bits 0 and 127: rule 0 wins, visible two cycles later, popped the next.
        bus.result_ready = 1'b1;
        bus.bv_in        = onehot(0) | onehot(127);
        bus.bv_in_valid  = 1'b1;
        step();
        bus.bv_in_valid = 1'b0;
        check("t1_not_yet", int'(bus.result_valid), 0);
        step();
        check("t1_valid", int'(bus.result_valid), 1);
        check("t1_hit", int'(bus.result_hit), 1);
        check("t1_id", int'(bus.result_id), 0);
        if (mq.size() != 0) check("t1_model_id", mq[0].id, 0);
        step();
        check("t1_popped", int'(bus.result_valid), 0);

        // Segment-boundary ids back-to-back.
        plog.delete();
        bus.bv_in_valid = 1'b1;
        bus.bv_in = onehot(37); step();
        bus.bv_in = onehot(16); step();
        bus.bv_in = onehot(15); step();
        bus.bv_in_valid = 1'b0;
        repeat (4) step();
        check("t2_count", plog.size(), 3);
        if (plog.size() == 3) begin
            check("t2_id0", plog[0].id, 37);
            check("t2_id1", plog[1].id, 16);
            check("t2_id2", plog[2].id, 15);
            check("t2_gap01", plog[1].cyc - plog[0].cyc, 1);
            check("t2_gap12", plog[2].cyc - plog[1].cyc, 1);
        end

        // All-zero vector still produces a (miss) result.
        bus.bv_in       = '0;
        bus.bv_in_valid = 1'b1;
        step();
        bus.bv_in_valid = 1'b0;
        step();
        check("t3_valid", int'(bus.result_valid), 1);
        check("t3_hit", int'(bus.result_hit), 0);
        check("t3_id", int'(bus.result_id), 0);
        step();

        // Overflow: 10 results into 8 slots.
        bus.result_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            bus.bv_in       = onehot(i);
            bus.bv_in_valid = 1'b1;
            step();
        end
        bus.bv_in_valid = 1'b0;
        step();
        step();
        check("t4_full", int'(bus.fifo_full), 1);
        check("t4_drops", int'(bus.drop_count), 2);
        plog.delete();
        bus.result_ready = 1'b1;
        repeat (10) step();
        check("t4_count", plog.size(), 8);
        for (int i = 0; i < plog.size(); i++) check($sformatf("t4_id%0d", i), plog[i].id, i);
        check("t4_empty", int'(bus.result_valid), 0);

        // Full FIFO, write and pop on the same edge.
        bus.result_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            bus.bv_in       = onehot(20 + i);
            bus.bv_in_valid = 1'b1;
            step();
        end
        bus.bv_in_valid = 1'b0;
        step();
        step();
        check("t5_full_pre", int'(bus.fifo_full), 1);
        bus.bv_in       = onehot(50);
        bus.bv_in_valid = 1'b1;
        step();
        bus.bv_in_valid  = 1'b0;
        bus.result_ready = 1'b1;
        step();
        bus.result_ready = 1'b0;
        check("t5_full_post", int'(bus.fifo_full), 1);
        check("t5_drops", int'(bus.drop_count), 2);
        plog.delete();
        bus.result_ready = 1'b1;
        repeat (10) step();
        check("t5_count", plog.size(), 8);
        if (plog.size() == 8) begin
            check("t5_first", plog[0].id, 21);
            check("t5_last", plog[7].id, 50);
        end

        // Reset with 3 queued and 1 in flight; a vector offered during reset is ignored.
        bus.result_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus.bv_in       = onehot(60 + i);
            bus.bv_in_valid = 1'b1;
            step();
        end
        reset     = 1'b0;
        bus.bv_in = onehot(99);
        step();
        reset           = 1'b1;
        bus.bv_in_valid = 1'b0;
        check("t6_valid", int'(bus.result_valid), 0);
        check("t6_drops", int'(bus.drop_count), 0);
        check("t6_full", int'(bus.fifo_full), 0);
        for (int i = 0; i < 4; i++) begin
            step();
            check($sformatf("t6_quiet%0d", i), int'(bus.result_valid), 0);
        end

        // Randomized traffic, alternating eager and stingy consumer phases.
        for (int ph = 0; ph < 6; ph++) begin
            for (int n = 0; n < 500; n++) begin
                bus.bv_in_valid  = ($urandom_range(0, 3) != 0);
                bus.bv_in        = rand_vec();
                bus.result_ready = (ph % 2 == 0) ? ($urandom_range(0, 3) != 0)
                                                 : ($urandom_range(0, 7) == 0);
                step();
            end
        end
        bus.bv_in_valid  = 1'b0;
        bus.result_ready = 1'b1;
        repeat (12) step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/bv_priority_encoder.md
BV_PRIORITY_ENCODER -- requirements
Module: bv_priority_encoder

Interface
REQ-001 SHALL have parameter: rule_num, 128, width of the incoming match bit vector; legal values 128, 256, 512, 1024.
REQ-002 SHALL have parameter: idx_w, 7, rule index width; must equal log2(rule_num).
REQ-003 SHALL have port: clk  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port: reset  input  1  synchronous, active-low reset.
REQ-005 SHALL have port: bv_in_valid  input  1  one-cycle qualifier for bv_in; no backpressure upstream.
REQ-006 SHALL have port: bv_in  input  rule_num  AND-ed match vector; bit k set = rule k matched.
REQ-007 SHALL have port: result_valid  output  1  FIFO head holds a result.
REQ-008 SHALL have port: result_hit  output  1  head result matched at least one rule.
REQ-009 SHALL have port: result_id  output  idx_w  head result's highest-priority matched rule index.
REQ-010 SHALL have port: result_ready  input  1  consumer accepts head this cycle.
REQ-011 SHALL have port: fifo_full  output  1  result FIFO holds 8 entries.
REQ-012 SHALL have port: drop_count  output  16  count of results discarded on overflow.

Function
REQ-013 SHALL treat rule 0 as highest priority: result_id = lowest set bit index of bv_in.
REQ-014 SHALL, for an all-zero vector, produce result_hit=0 and result_id=0.
REQ-015 SHALL ignore bv_in in cycles where bv_in_valid=0.
REQ-016 SHALL implement pipeline stage 1: split bv_in into rule_num/16 segments of 16 bits and register, per segment, an any-bit flag and a 4-bit lowest-set-bit offset, plus a stage-1 valid.
REQ-017 SHALL implement stage 2: select the lowest-numbered segment with its flag set; compute id = seg*16 + offset and hit = OR of all flags; write {hit,id} to the FIFO on the next edge.
REQ-018 SHALL have a latency of 2 cycles: a vector sampled in cycle N, with the FIFO empty, gives result_valid=1 in cycle N+2; there is no bypass path.
REQ-019 SHALL accept one vector per cycle back-to-back with no bubbles.
REQ-020 SHALL use an 8-deep first-word-fall-through result FIFO; result_valid = not empty; result_hit and result_id drive the head entry.
REQ-021 SHALL pop when result_valid=1 and result_ready=1; result_ready while empty has no effect.
REQ-022 SHALL wrap read and write pointers modulo 8, with an occupancy count of 0..8; fifo_full=1 when count=8.
REQ-023 SHALL, on a write when full with no pop in the same cycle, discard the new result, leave FIFO contents unchanged, and increment drop_count.
REQ-024 SHALL, on a write and a pop in the same cycle while full, perform both; no drop, count stays 8.
REQ-025 SHALL, on a write and a pop in the same cycle with 0<count<8, leave count unchanged.
REQ-026 SHALL saturate drop_count at 16'hFFFF; it clears only on reset.
REQ-027 SHALL deliver results in input order.

Reset
REQ-028 SHALL, while reset=0 at a clock edge, clear stage-1 and stage-2 valids, FIFO pointers and count, result_valid, result_hit, result_id, fifo_full and drop_count to 0.
REQ-029 SHALL discard vectors in flight at reset; none emerge after reset deasserts.
REQ-030 SHALL ignore bv_in_valid during a cycle in which reset=0.

Verification
REQ-031 SHALL pass: bv_in bits 0 and 127 set, ready=1 -> 2 cycles later result_valid=1, hit=1, id=0, popped next cycle.
REQ-032 SHALL pass: separate vectors with only bit 37, only bit 16, and only bit 15 -> ids 37, 16, 15 in order, back-to-back cycles.
REQ-033 SHALL pass: all-zero vector -> result_valid=1, hit=0, id=0.
REQ-034 SHALL pass: ready=0, 10 consecutive vectors with ids 0..9 -> fifo_full=1, drop_count=2; then ready=1 -> ids 0..7 out in order, then result_valid=0.
REQ-035 SHALL pass: FIFO full, ready=1 and a new write in the same cycle -> drop_count unchanged, fifo_full stays 1, new id appears last.
REQ-036 SHALL pass: 3 entries queued plus 1 in the pipeline, reset=0 for one cycle -> next cycle result_valid=0, drop_count=0, and no result appears in the following 4 cycles.
